// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: packs core register writebacks and data-memory accesses
// into trace records, buffers them in a dual-push FIFO and drains them over a
// valid/ready stream. Records that do not fit are counted in overflow_cnt.
// Optional macro TRACE_TIMESTAMP_EN adds a per-record cycle stamp (out_cycle).
module riscv_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [ADDR_W-1:0]        out_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              overflow_cnt
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]              out_cycle
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    logic [1:0]        r_kind [DEPTH];
    logic [ADDR_W-1:0] r_idx  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       r_stamp [DEPTH];
    logic [31:0]       r_cycle;
`endif

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [15:0]       r_ovf;

    logic              w_memEv;
    logic              w_regEv;
    logic [1:0]        w_memKind;
    logic [DATA_W-1:0] w_memData;
    logic [ADDR_W-1:0] w_regIdx;
    logic [LVL_W-1:0]  w_free;
    logic [1:0]        w_numEv;
    logic [1:0]        w_numPush;
    logic [1:0]        w_numDrop;
    logic              w_pop;
    logic [1:0]        w_firstKind;
    logic [ADDR_W-1:0] w_firstIdx;
    logic [DATA_W-1:0] w_firstData;
    logic [PTR_W-1:0]  w_wptrNext;
    logic [PTR_W-1:0]  w_headPtr;
    logic [16:0]       w_ovfSum;

    // Classify this cycle's events and decide how many records fit; space is judged before any pop.
    always_comb begin
        w_memEv     = wr | rd;
        w_memKind   = wr ? KIND_STORE : KIND_LOAD;
        w_memData   = wr ? wr_data : rd_data;
        w_regEv     = reg_write_sig && (reg_num != 5'd0);
        w_regIdx    = ADDR_W'(reg_num);
        w_numEv     = {1'b0, w_memEv} + {1'b0, w_regEv};
        w_free      = LVL_W'(DEPTH) - r_level;
        if (w_free >= LVL_W'(w_numEv)) begin
            w_numPush = w_numEv;
        end else begin
            w_numPush = w_free[1:0];
        end
        w_numDrop   = w_numEv - w_numPush;
        w_pop       = (r_level != '0) && out_ready;
        w_wptrNext  = r_wptr + PTR_W'(1);
        w_ovfSum    = {1'b0, r_ovf} + 17'(w_numDrop);
        if (w_memEv) begin
            w_firstKind = w_memKind;
            w_firstIdx  = addr;
            w_firstData = w_memData;
        end else begin
            w_firstKind = KIND_REG;
            w_firstIdx  = w_regIdx;
            w_firstData = reg_data;
        end
        // When empty, the slot behind the read pointer still holds the last record shown.
        w_headPtr   = (r_level == '0) ? (r_rptr - PTR_W'(1)) : r_rptr;
    end

    // FIFO storage, pointers and occupancy; the mem record always takes the first slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_kind[i] <= '0;
                r_idx[i]  <= '0;
                r_data[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_numPush != 2'd0) begin
                r_kind[r_wptr] <= w_firstKind;
                r_idx[r_wptr]  <= w_firstIdx;
                r_data[r_wptr] <= w_firstData;
            end
            if (w_numPush == 2'd2) begin
                r_kind[w_wptrNext] <= KIND_REG;
                r_idx[w_wptrNext]  <= w_regIdx;
                r_data[w_wptrNext] <= reg_data;
            end
            r_wptr <= r_wptr + PTR_W'(w_numPush);
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_numPush) - LVL_W'(w_pop);
        end
    end

    // Saturating count of records dropped for lack of space.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_ovfSum[16] ? 16'hFFFF : w_ovfSum[15:0];
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    // Free-running cycle counter and per-slot stamps; paired records share one stamp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stamp[i] <= '0;
            end
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_numPush != 2'd0) begin
                r_stamp[r_wptr] <= r_cycle;
            end
            if (w_numPush == 2'd2) begin
                r_stamp[w_wptrNext] <= r_cycle;
            end
        end
    end

    assign out_cycle = r_stamp[w_headPtr];
`endif

    assign out_valid    = (r_level != '0);
    assign out_kind     = r_kind[w_headPtr];
    assign out_idx      = r_idx[w_headPtr];
    assign out_data     = r_data[w_headPtr];
    assign level        = r_level;
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: table-driven vectors plus hand-written sequences for
// overflow, async reset and pointer wrap; a queue scoreboard holds the records
// the sink should see, in order.
module tb_riscv_trace_buffer;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [8:0]  out_idx;
    logic [31:0] out_data;
    logic [LVL_W-1:0] level;
    logic [15:0] overflow_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] out_cycle;
`endif

    riscv_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_kind      (out_kind),
        .out_idx       (out_idx),
        .out_data      (out_data),
        .level         (level),
        .overflow_cnt  (overflow_cnt)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .out_cycle     (out_cycle)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rn;
        logic [31:0] rdat;
        logic        w;
        logic        r;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] rdd;
        logic        rdy;
    } stim_t;

    typedef struct {
        stim_t s;
        int    expLevel;
    } vec_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  idx;
        logic [31:0] data;
    } rec_t;

    rec_t sbQ[$];
    int   mLevel   = 0;
    int   mOvf     = 0;
    int   popCount = 0;
    int   checks   = 0;
    int   passes   = 0;
    vec_t vecs[14];

    // One comparison: bump the totals and report any difference.
    task automatic checkVal(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // The head record on the stream must match the scoreboard's oldest entry.
    task automatic checkOutput(input rec_t exp);
        checkVal("head_kind", out_kind, exp.kind);
        checkVal("head_idx", out_idx, exp.idx);
        checkVal("head_data", out_data, exp.data);
    endtask

    function automatic stim_t mkIdle(input logic rdy);
        stim_t s = '0;
        s.rdy = rdy;
        return s;
    endfunction

    function automatic stim_t mkReg(input logic [4:0] rn, input logic [31:0] d, input logic rdy);
        stim_t s = mkIdle(rdy);
        s.rw = 1'b1; s.rn = rn; s.rdat = d;
        return s;
    endfunction

    function automatic stim_t mkLoad(input logic [8:0] a, input logic [31:0] d, input logic rdy);
        stim_t s = mkIdle(rdy);
        s.r = 1'b1; s.a = a; s.rdd = d;
        return s;
    endfunction

    function automatic stim_t mkStore(input logic [8:0] a, input logic [31:0] d, input logic rdy);
        stim_t s = mkIdle(rdy);
        s.w = 1'b1; s.a = a; s.wd = d;
        return s;
    endfunction

    // Drive one cycle: check the head, update the reference queue, then check level and drops after the edge.
    task automatic applyStimulus(input stim_t s);
        int   free;
        int   nPush;
        bit   pop;
        rec_t rec;
        @(negedge clk);
        reg_write_sig = s.rw; reg_num = s.rn; reg_data = s.rdat;
        wr = s.w; rd = s.r; addr = s.a; wr_data = s.wd; rd_data = s.rdd;
        out_ready = s.rdy;
        #1;
        checkVal("out_valid", out_valid, (mLevel != 0));
        pop = (mLevel != 0) && s.rdy;
        if (mLevel != 0) checkOutput(sbQ[0]);
        if (pop) begin
            void'(sbQ.pop_front());
            popCount++;
        end
        free  = DEPTH - mLevel;
        nPush = 0;
        if (s.w || s.r) begin
            rec.kind = s.w ? 2'd2 : 2'd1;
            rec.idx  = s.a;
            rec.data = s.w ? s.wd : s.rdd;
            if (free > 0) begin sbQ.push_back(rec); free--; nPush++; end
            else mOvf++;
        end
        if (s.rw && s.rn != 5'd0) begin
            rec.kind = 2'd0;
            rec.idx  = {4'b0, s.rn};
            rec.data = s.rdat;
            if (free > 0) begin sbQ.push_back(rec); free--; nPush++; end
            else mOvf++;
        end
        if (mOvf > 65535) mOvf = 65535;
        mLevel = mLevel + nPush - int'(pop);
        @(posedge clk);
        #1;
        checkVal("level", level, mLevel);
        checkVal("overflow_cnt", overflow_cnt, mOvf);
    endtask

    // Idle with the sink ready until the reference queue is empty, bounded.
    task automatic drain(input string name);
        for (int i = 0; i < 4 * DEPTH && mLevel != 0; i++) applyStimulus(mkIdle(1'b1));
        checkVal(name, level, 0);
    endtask

    // Bail out with a failure line if the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   base;
        stim_t s;

        // Directed table: single regwrite, x0 filter with load, dual ordering, store-wins, pop+push.
        vecs[0]  = '{mkReg(5'd5, 32'hDEADBEEF, 1'b1), 1};
        vecs[1]  = '{mkIdle(1'b1), 0};
        vecs[2]  = '{mkIdle(1'b1), 0};
        s = mkLoad(9'h1F0, 32'h55, 1'b1); s.rw = 1'b1; s.rn = 5'd0; s.rdat = 32'h123;
        vecs[3]  = '{s, 1};
        vecs[4]  = '{mkIdle(1'b1), 0};
        s = mkStore(9'h010, 32'd7, 1'b0); s.rw = 1'b1; s.rn = 5'd3; s.rdat = 32'd9;
        vecs[5]  = '{s, 2};
        vecs[6]  = '{mkIdle(1'b0), 2};
        vecs[7]  = '{mkIdle(1'b1), 1};
        vecs[8]  = '{mkIdle(1'b1), 0};
        s = mkStore(9'h022, 32'hAAAA, 1'b1); s.r = 1'b1; s.rdd = 32'hBBBB;
        vecs[9]  = '{s, 1};
        vecs[10] = '{mkIdle(1'b1), 0};
        vecs[11] = '{mkReg(5'd31, 32'd1, 1'b1), 1};
        vecs[12] = '{mkReg(5'd7, 32'd2, 1'b1), 1};
        vecs[13] = '{mkIdle(1'b1), 0};

        reset = 1'b1;
        reg_write_sig = 0; reg_num = 0; reg_data = 0; wr = 0; rd = 0;
        addr = 0; wr_data = 0; rd_data = 0; out_ready = 0;
        #3;
        checkVal("rst_valid", out_valid, 0);
        checkVal("rst_kind", out_kind, 0);
        checkVal("rst_idx", out_idx, 0);
        checkVal("rst_data", out_data, 0);
        checkVal("rst_level", level, 0);
        checkVal("rst_ovf", overflow_cnt, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].s);
            checkVal($sformatf("tbl_level[%0d]", i), level, vecs[i].expLevel);
        end

        // Fill to one free slot, then a dual event keeps only the mem record.
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) applyStimulus(mkReg(5'(i + 1), 32'(100 + 3 * i), 1'b0));
            else applyStimulus(mkLoad(9'(4 * i), 32'(i), 1'b0));
        end
        s = mkStore(9'h1AB, 32'hCAFE, 1'b0); s.rw = 1'b1; s.rn = 5'd9; s.rdat = 32'h99;
        applyStimulus(s);
        checkVal("ovf_full_level", level, 16);
        checkVal("ovf_dual_cnt", overflow_cnt, 1);
        applyStimulus(mkReg(5'd4, 32'h44, 1'b0));
        checkVal("ovf_single_cnt", overflow_cnt, 2);
        s = mkLoad(9'h033, 32'h33, 1'b0); s.rw = 1'b1; s.rn = 5'd6; s.rdat = 32'h66;
        applyStimulus(s);
        checkVal("ovf_both_dropped", overflow_cnt, 4);
        // A pop in the same cycle does not make room for the push.
        applyStimulus(mkReg(5'd8, 32'h88, 1'b1));
        checkVal("ovf_pop_no_room", overflow_cnt, 5);
        checkVal("ovf_pop_level", level, 15);
        drain("ovf_drain_level");

        // Build level 6 mid-drain, then assert reset between edges.
        for (int i = 0; i < 8; i++) applyStimulus(mkReg(5'(i + 10), 32'(i * 17), 1'b0));
        applyStimulus(mkIdle(1'b1));
        applyStimulus(mkIdle(1'b1));
        checkVal("pre_reset_level", level, 6);
        #2 reset = 1'b1;
        #1;
        checkVal("areset_valid", out_valid, 0);
        checkVal("areset_level", level, 0);
        checkVal("areset_ovf", overflow_cnt, 0);
        checkVal("areset_data", out_data, 0);
        sbQ.delete();
        mLevel = 0;
        mOvf   = 0;
        #1 reset = 1'b0;
        applyStimulus(mkIdle(1'b1));
        applyStimulus(mkReg(5'd12, 32'h1234, 1'b0));
        checkVal("post_reset_level", level, 1);
`ifdef TRACE_TIMESTAMP_EN
        checkVal("post_reset_stamp", out_cycle, 1);
`endif
        drain("post_reset_drain");

        // 40 alternating reg/load events under toggling ready; pointers wrap several times.
        base = popCount;
        for (int k = 0; k < 80; k++) begin
            if (k % 2 == 0) begin
                if ((k / 2) % 2 == 0) applyStimulus(mkReg(5'(1 + (k / 2) % 31), $urandom, 1'b0));
                else applyStimulus(mkLoad(9'($urandom_range(0, 511)), $urandom, 1'b0));
            end else begin
                applyStimulus(mkIdle(1'b1));
            end
        end
        drain("wrap_drain_level");
        checkVal("wrap_records", popCount - base, 40);
        checkVal("wrap_ovf", overflow_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
